// File: rtl/linear_layer_fifo_pkg.sv
// Shared constants and helpers for the Linear_Layer start-token FIFOs.
package linear_layer_fifo_pkg;

    localparam int unsigned DefaultAddrWidth = 3;
    localparam int unsigned DefaultCntWidth  = DefaultAddrWidth + 1;

    // Smallest read-address width able to index every entry of a FIFO of the given depth.
    function automatic int unsigned min_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than the address.
    function automatic int unsigned cnt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl_mem.sv
// Addressable shift-register storage: a write shifts every entry up by one and lands at index 0.
module linear_layer_start_fifo_srl_mem
    import linear_layer_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DEPTH      = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] sr_q [DEPTH];

    // Contents are deliberately unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[addr];

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO controller: occupancy, registered full/empty flags, read address and handshake.
module linear_layer_start_fifo_srl
    import linear_layer_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DEPTH      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int unsigned    CntW     = cnt_width(ADDR_WIDTH);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [CntW-1:0]       cnt_q, cnt_d, cnt_m1;
    logic                  full_n_q, empty_n_q;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] addr;

    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read & if_read_ce & empty_n_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Oldest entry sits at cnt-1; a concurrent push shifts it to cnt, exposing the next-oldest.
    assign cnt_m1 = cnt_q - 1'b1;
    assign addr   = (cnt_q == '0) ? '0 : cnt_m1[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            empty_n_q <= (cnt_d != '0);
            full_n_q  <= (cnt_d != DepthCnt);
        end
    end

    linear_layer_start_fifo_srl_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .addr (addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = cnt_q;
    assign if_fifo_cap       = DepthCnt;

    cnt_overflow_a : assert property (@(posedge clk) disable iff (reset) cnt_q <= DepthCnt)
        else $error("occupancy above capacity");
    cnt_underflow_a : assert property (@(posedge clk) disable iff (reset) !(pop && cnt_q == '0))
        else $error("pop from empty FIFO");

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Randomized and directed bench for the start-token FIFO against a queue-based reference.
module tb_linear_layer_start_fifo_srl;

    localparam int unsigned DW    = 1;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_full_n, if_empty_n;
    logic          if_write_ce = 1'b0, if_write = 1'b0;
    logic          if_read_ce = 1'b0, if_read = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_num_data_valid, if_fifo_cap;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [DW-1:0] model_q [$];

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_full_n         (if_full_n),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_empty_n        (if_empty_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 32'(if_num_data_valid), model_q.size());
        check_eq({tag, ".empty_n"}, 32'(if_empty_n), 32'(model_q.size() != 0));
        check_eq({tag, ".full_n"}, 32'(if_full_n), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) check_eq({tag, ".dout"}, 32'(if_dout), 32'(model_q[0]));
    endtask

    // One clock: drive inputs, let the edge happen, advance the reference, compare 1 ns later.
    task automatic cycle(input logic rst, input logic w, input logic wce, input logic [DW-1:0] d,
                         input logic r, input logic rce, input string tag);
        bit do_push, do_pop;
        reset = rst; if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
        do_push = w && wce && (model_q.size() < DEPTH);
        do_pop  = r && rce && (model_q.size() > 0);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        check_state(tag);
    endtask

    task automatic push(input logic [DW-1:0] d, input string tag);
        cycle(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0, tag);
    endtask

    task automatic pop(input string tag);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, tag);
    endtask

    initial begin
        logic [5:0] pat;
        pat = 6'b101101;

        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "reset");
        check_eq("reset.count0", 32'(if_num_data_valid), 0);
        check_eq("reset.empty_n0", 32'(if_empty_n), 0);
        check_eq("reset.full_n1", 32'(if_full_n), 1);
        check_eq("fifo_cap", 32'(if_fifo_cap), DEPTH);

        // Single token round trip
        push(1'b1, "t1.push");
        check_eq("t1.dout1", 32'(if_dout), 1);
        pop("t1.pop");
        check_eq("t1.empty", 32'(if_empty_n), 0);

        // Fill, overflow attempt, drain in order
        for (int i = 0; i < 6; i++) push(pat[5-i], "t2.fill");
        check_eq("t2.full_n0", 32'(if_full_n), 0);
        push(1'b0, "t2.over");
        check_eq("t2.count6", 32'(if_num_data_valid), 6);
        for (int i = 0; i < 6; i++) begin
            check_eq("t2.drain", 32'(if_dout), 32'(pat[5-i]));
            pop("t2.pop");
        end

        // Steady-state streaming at occupancy 3
        for (int i = 0; i < 3; i++) push(DW'(i & 1), "t3.pre");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, DW'(i & 1), 1'b1, 1'b1, "t3.stream");
            check_eq("t3.count3", 32'(if_num_data_valid), 3);
        end
        for (int i = 0; i < 3; i++) pop("t3.drain");

        // Full with simultaneous push and pop: only the pop lands
        for (int i = 0; i < 6; i++) push(1'b0, "t4.fill");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t4.pp");
        check_eq("t4.count5", 32'(if_num_data_valid), 5);
        check_eq("t4.full_n1", 32'(if_full_n), 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4.no_token", 32'(if_dout), 0);
            pop("t4.drain");
        end

        // Requests without clock-enable are ignored
        push(1'b1, "t5.pre");
        push(1'b0, "t5.pre");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5.noce");
            check_eq("t5.count2", 32'(if_num_data_valid), 2);
        end

        // Reset wins over a concurrent push
        push(1'b1, "t6.pre");
        push(1'b1, "t6.pre");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t6.rst");
        check_eq("t6.count0", 32'(if_num_data_valid), 0);
        check_eq("t6.full_n", 32'(if_full_n), 1);
        push(1'b1, "t6.push");
        pop("t6.pop");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                  DW'($urandom), $urandom_range(0, 1), ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_layer_start_fifo_srl.md
Name: linear_layer_start_fifo_srl

Overview:
Start-token FIFO controller placed between two dataflow processes of Linear_Layer_i4xi4_q. Examples of such pairs are the feeder and a PE_i4xi4_pack_2x2 instance. Producer side pushes one start token per launched task. Consumer side pops one token per task start. Storage is an addressable shift register; this block owns occupancy tracking, full/empty flags, the read address and the handshake.

Parameters:
DATA_WIDTH, 1, token width in bits.
ADDR_WIDTH, 3, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
DEPTH, 6, FIFO capacity in entries; legal range 2..2**ADDR_WIDTH.

Ports:
clk  input  1  single clock; all logic posedge.
reset  input  1  synchronous, active-high reset.
if_full_n  output  1  high = space available (registered).
if_write_ce  input  1  write clock-enable.
if_write  input  1  write request.
if_din  input  DATA_WIDTH  write data.
if_empty_n  output  1  high = data available (registered).
if_read_ce  input  1  read clock-enable.
if_read  input  1  read request.
if_dout  output  DATA_WIDTH  oldest entry; combinational from storage.
if_num_data_valid  output  ADDR_WIDTH+1  current occupancy 0..DEPTH.
if_fifo_cap  output  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Handshake qualifiers:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - Requests are ignored while the matching flag is low, with no error and no state change.
- Storage: on push, the shift register shifts entry i to i+1 and writes if_din at index 0. Storage contents are not reset.
- Occupancy register cnt (ADDR_WIDTH+1 bits):
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged.
  - neither: hold.
- Read address:
  - addr = cnt-1, truncated to ADDR_WIDTH, when cnt>0.
  - addr = 0 when cnt=0.
  - if_dout = storage[addr], which is always the oldest entry.
- Simultaneous push+pop with cnt>0: the shift moves the oldest entry to index cnt, and addr stays cnt-1, so the next-oldest entry is presented. No bubble.
- Flag update, registered and computed from next-state cnt:
  - if_empty_n <= (cnt_next != 0).
  - if_full_n <= (cnt_next != DEPTH).
- Latency:
  - A push at edge N raises if_empty_n after edge N. The token is readable in cycle N+1.
  - A pop at edge N raises if_full_n after edge N when the FIFO was full.
- Boundaries:
  - Empty (cnt=0): pop is impossible. A push alone makes cnt=1.
  - Full (cnt=DEPTH): push is blocked even when a pop occurs in the same cycle. After that cycle cnt=DEPTH-1 and if_full_n=1.
  - if_dout is don't-care while if_empty_n=0, but must not be X-propagating into control.
- Reset (synchronous, when reset=1 at a posedge):
  - cnt=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
  - Reset wins over a push or pop in the same cycle. Tokens in flight mid-operation are discarded.
  - Before the first clock edge, outputs are undefined; the bench must apply reset first.
- if_num_data_valid = cnt (registered). if_fifo_cap is a tie-off.
- Arithmetic: cnt never wraps. Assertions must fire if cnt > DEPTH or on underflow.

Decomposition:
- Shared package holds:
  - a localparam function for the minimum address width, clog2(DEPTH).
  - the occupancy width constant, ADDR_WIDTH+1.
  - Package name: linear_layer_fifo_pkg.
- One sub-module: linear_layer_start_fifo_srl_mem. It is the shift-register storage with ports clk, we, addr, din, dout; we is driven by push.
- The controller, flag logic and assertions stay in the top.

Test Plan:
1. Reset, then a single push of din=1 at cycle 0 -> cycle 1: if_empty_n=1, if_dout=1, if_num_data_valid=1. Pop at cycle 1 -> cycle 2: if_empty_n=0, count 0.
2. Six pushes of 1,0,1,1,0,1 with no pop -> if_full_n=0 after the 6th. A 7th push is ignored and count stays 6. Six pops then return 1,0,1,1,0,1 in order.
3. cnt=3, then push+pop every cycle for 10 cycles with an alternating pattern -> count stays 3, if_dout sequence is FIFO-ordered, flags constant.
4. Full FIFO, simultaneous push+pop -> only the pop takes effect: count 5, if_full_n=1 next cycle, the pushed token is absent.
5. if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 -> no state change for 5 cycles.
6. cnt=4, assert reset concurrently with push -> next cycle count 0, if_empty_n=0, if_full_n=1. A subsequent push/pop operates normally.
